// File: rtl/ps2_keyboard_latch.sv
// ============================================================================
//  Module      : ps2_keyboard_latch
//  Description : PS/2 scancode-set-2 receiver and ASCII decoder feeding an
//                Apple-I-style keyboard latch (bit 7 = key available).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_latch #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       keystrobe,
    output logic [7:0] keycode,
    output logic       key_lost
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] c_filt_max = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] c_timeout  = WW'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Index 0 = PS/2 clock, index 1 = PS/2 data.
    logic [1:0] w_pin;
    logic [1:0] w_filt;
    assign w_pin = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            logic          r_s1;
            logic          r_s2;
            logic          r_filt;
            logic [FW-1:0] r_cnt;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_s1   <= 1'b1;
                    r_s2   <= 1'b1;
                    r_filt <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_s1 <= w_pin[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_filt_max) begin
                        r_filt <= r_s2;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic w_clk_f;
    logic w_dat_f;
    logic r_clk_f_d;
    logic w_fall;
    assign w_clk_f = w_filt[0];
    assign w_dat_f = w_filt[1];
    assign w_fall  = r_clk_f_d & ~w_clk_f;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_sr;
    logic          r_par_ok;
    logic [WW-1:0] r_wd;
    logic          w_wd_expire;
    logic          r_byte_valid;
    logic [7:0]    r_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wd_expire = (r_state != S_IDLE) && (r_wd == c_timeout) && !w_fall;
        if (w_wd_expire) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_dat_f) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_f_d    <= 1'b1;
            r_bit_cnt    <= 3'd0;
            r_sr         <= 8'h00;
            r_par_ok     <= 1'b0;
            r_wd         <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'h00;
        end else begin
            r_clk_f_d    <= w_clk_f;
            r_byte_valid <= 1'b0;
            if (r_state == S_IDLE || w_fall || w_wd_expire) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    S_IDLE: r_bit_cnt <= 3'd0;
                    S_DATA: begin
                        r_sr      <= {w_dat_f, r_sr[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_par_ok <= ^{r_sr, w_dat_f};
                    default: begin
                        r_byte_valid <= w_dat_f & r_par_ok;
                        r_byte       <= r_sr;
                    end
                endcase
            end
        end
    end

    // Returns the uppercase letter for a letter make code, 0 otherwise.
    function automatic logic [6:0] letter_of(input logic [7:0] code);
        case (code)
            8'h1C: letter_of = 7'h41;  8'h32: letter_of = 7'h42;
            8'h21: letter_of = 7'h43;  8'h23: letter_of = 7'h44;
            8'h24: letter_of = 7'h45;  8'h2B: letter_of = 7'h46;
            8'h34: letter_of = 7'h47;  8'h33: letter_of = 7'h48;
            8'h43: letter_of = 7'h49;  8'h3B: letter_of = 7'h4A;
            8'h42: letter_of = 7'h4B;  8'h4B: letter_of = 7'h4C;
            8'h3A: letter_of = 7'h4D;  8'h31: letter_of = 7'h4E;
            8'h44: letter_of = 7'h4F;  8'h4D: letter_of = 7'h50;
            8'h15: letter_of = 7'h51;  8'h2D: letter_of = 7'h52;
            8'h1B: letter_of = 7'h53;  8'h2C: letter_of = 7'h54;
            8'h3C: letter_of = 7'h55;  8'h2A: letter_of = 7'h56;
            8'h1D: letter_of = 7'h57;  8'h22: letter_of = 7'h58;
            8'h35: letter_of = 7'h59;  8'h1A: letter_of = 7'h5A;
            default: letter_of = 7'h00;
        endcase
    endfunction

    // {hit, unshifted glyph, shifted glyph} for non-letter keys.
    function automatic logic [14:0] glyph_of(input logic [7:0] code);
        case (code)
            8'h16: glyph_of = {1'b1, 7'h31, 7'h21};
            8'h1E: glyph_of = {1'b1, 7'h32, 7'h40};
            8'h26: glyph_of = {1'b1, 7'h33, 7'h23};
            8'h25: glyph_of = {1'b1, 7'h34, 7'h24};
            8'h2E: glyph_of = {1'b1, 7'h35, 7'h25};
            8'h36: glyph_of = {1'b1, 7'h36, 7'h5E};
            8'h3D: glyph_of = {1'b1, 7'h37, 7'h26};
            8'h3E: glyph_of = {1'b1, 7'h38, 7'h2A};
            8'h46: glyph_of = {1'b1, 7'h39, 7'h28};
            8'h45: glyph_of = {1'b1, 7'h30, 7'h29};
            8'h0E: glyph_of = {1'b1, 7'h60, 7'h7E};
            8'h4E: glyph_of = {1'b1, 7'h2D, 7'h5F};
            8'h55: glyph_of = {1'b1, 7'h3D, 7'h2B};
            8'h54: glyph_of = {1'b1, 7'h5B, 7'h7B};
            8'h5B: glyph_of = {1'b1, 7'h5D, 7'h7D};
            8'h5D: glyph_of = {1'b1, 7'h5C, 7'h7C};
            8'h4C: glyph_of = {1'b1, 7'h3B, 7'h3A};
            8'h52: glyph_of = {1'b1, 7'h27, 7'h22};
            8'h41: glyph_of = {1'b1, 7'h2C, 7'h3C};
            8'h49: glyph_of = {1'b1, 7'h2E, 7'h3E};
            8'h4A: glyph_of = {1'b1, 7'h2F, 7'h3F};
            8'h29: glyph_of = {1'b1, 7'h20, 7'h20};
            8'h5A: glyph_of = {1'b1, 7'h0D, 7'h0D};
            8'h66: glyph_of = {1'b1, 7'h5F, 7'h5F};
            8'h76: glyph_of = {1'b1, 7'h1B, 7'h1B};
            default: glyph_of = 15'h0000;
        endcase
    endfunction

    logic       r_brk;
    logic       r_ext;
    logic       r_shift_l;
    logic       r_shift_r;
    logic       r_ctrl;
    logic [6:0] w_letter;
    logic [14:0] w_glyph;
    logic       w_shift;
    logic       w_hit;
    logic [6:0] w_ascii;
    logic       w_is_prefix;
    logic       w_is_mod;
    logic       w_key_valid;

    always_comb begin
        w_letter    = letter_of(r_byte);
        w_glyph     = glyph_of(r_byte);
        w_shift     = r_shift_l | r_shift_r;
        w_hit       = 1'b0;
        w_ascii     = 7'h00;
        if (w_letter != 7'h00) begin
            w_hit = 1'b1;
            if (r_ctrl) begin
                w_ascii = w_letter - 7'h40;
            end else if (w_shift) begin
                w_ascii = w_letter;
            end else begin
                w_ascii = w_letter | 7'h20;
            end
        end else if (w_glyph[14]) begin
            w_hit   = 1'b1;
            w_ascii = w_shift ? w_glyph[6:0] : w_glyph[13:7];
        end
        w_is_prefix = (r_byte == 8'hF0) || (r_byte == 8'hE0);
        w_is_mod    = (r_byte == 8'h12) || (r_byte == 8'h59) || (r_byte == 8'h14);
        w_key_valid = r_byte_valid && !w_is_prefix && !w_is_mod && !r_brk && !r_ext && w_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
            r_ctrl    <= 1'b0;
        end else if (r_byte_valid) begin
            if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (!r_ext) begin
                    if (r_byte == 8'h12) r_shift_l <= !r_brk;
                    if (r_byte == 8'h59) r_shift_r <= !r_brk;
                    if (r_byte == 8'h14) r_ctrl    <= !r_brk;
                end
            end
        end
    end

    logic r_ks;
    logic r_ks_prev;
    logic w_ack;
    assign w_ack = r_ks & ~r_ks_prev;

    // A coinciding acknowledge frees the latch for the incoming key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ks      <= 1'b0;
            r_ks_prev <= 1'b0;
            keycode   <= 8'h00;
            key_lost  <= 1'b0;
        end else begin
            r_ks      <= keystrobe;
            r_ks_prev <= r_ks;
            key_lost  <= 1'b0;
            if (w_key_valid) begin
                if (!keycode[7] || w_ack) begin
                    keycode <= {1'b1, w_ascii};
                end else begin
                    key_lost <= 1'b1;
                end
            end else if (w_ack) begin
                keycode[7] <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_latch.sv
// ============================================================================
//  Module      : tb_ps2_keyboard_latch
//  Description : Directed self-checking bench for ps2_keyboard_latch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_keyboard_latch;

    localparam int HALF = 20;
    localparam int TO   = 1000;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       keystrobe = 1'b0;
    logic [7:0] keycode;
    logic       key_lost;

    int n_total  = 0;
    int n_pass   = 0;
    int lost_cnt = 0;
    int exp_lost = 0;

    ps2_keyboard_latch #(
        .FILTER_LEN (4),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keystrobe (keystrobe),
        .keycode   (keycode),
        .key_lost  (key_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_lost === 1'b1) lost_cnt++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // mode 1: cycle-exact latency check on the stop edge; mode 2: ack coincides with the load.
    task automatic send_bits(input logic [10:0] f, input int n, input int mode,
                             input logic [7:0] e_before, input logic [7:0] e_after);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                repeat (7) @(posedge clk);
                #1 chk("lat_n1", keycode, e_before);
                @(posedge clk);
                #1 chk("lat_n2", keycode, e_after);
            end else if (i == 10 && mode == 2) begin
                repeat (6) @(posedge clk);
                @(negedge clk) keystrobe = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk) ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b0), 11, 0, 8'h00, 8'h00);
    endtask

    task automatic ack();
        @(negedge clk) keystrobe = 1'b0;
        repeat (2) @(negedge clk);
        keystrobe = 1'b1;
        repeat (3) @(negedge clk);
        keystrobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_keycode", keycode, 8'h00);
        chk("reset_lost", {7'd0, key_lost}, 8'h00);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Plain key with exact load latency
        send_bits(frame(8'h1C, 1'b0, 1'b0), 11, 1, 8'h00, 8'hE1);
        chk("plain_lost", 8'(lost_cnt), 8'(exp_lost));

        // Acknowledge held for 10 cycles
        @(negedge clk) keystrobe = 1'b1;
        @(posedge clk);
        #1 chk("ack_edge", keycode, 8'hE1);
        @(posedge clk);
        #1 chk("ack_clear", keycode, 8'h61);
        repeat (9) @(posedge clk);
        #1 chk("ack_hold", keycode, 8'h61);
        @(negedge clk) keystrobe = 1'b0;
        send(8'h5A);
        chk("enter", keycode, 8'h8D);

        // Shift make/break sequence, then a key into a full latch
        ack();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        chk("shift_A", keycode, 8'hC1);
        chk("shift_lost", 8'(lost_cnt), 8'(exp_lost));
        send(8'h1C);
        exp_lost++;
        chk("full_keep", keycode, 8'hC1);
        chk("full_lost", 8'(lost_cnt), 8'(exp_lost));

        // Frame errors
        do_reset();
        send_bits(frame(8'h1C, 1'b1, 1'b0), 11, 0, 8'h00, 8'h00);
        chk("bad_parity", keycode, 8'h00);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 0, 8'h00, 8'h00);
        chk("bad_stop", keycode, 8'h00);
        send(8'h29);
        chk("space_after_err", keycode, 8'hA0);

        // Watchdog aborts a partial frame
        do_reset();
        send_bits(frame(8'h1C, 1'b0, 1'b0), 5, 0, 8'h00, 8'h00);
        repeat (TO + 5) @(negedge clk);
        send(8'h1C);
        chk("watchdog", keycode, 8'hE1);

        // Acknowledge edge coincides with the load of Esc
        send_bits(frame(8'h76, 1'b0, 1'b0), 11, 2, 8'h00, 8'h00);
        chk("simul_esc", keycode, 8'h9B);
        chk("simul_lost", 8'(lost_cnt), 8'(exp_lost));

        // Ctrl+A, shifted digit, extended prefix
        ack();
        send(8'h14); send(8'h1C);
        chk("ctrl_a", keycode, 8'h81);
        send(8'hF0); send(8'h14);
        ack();
        send(8'h12); send(8'h16);
        chk("shift_1", keycode, 8'hA1);
        send(8'hF0); send(8'h12);
        ack();
        send(8'hE0); send(8'h1C);
        chk("ext_ignored", keycode, 8'h21);
        send(8'h1C);
        chk("after_ext", keycode, 8'hE1);

        // Reset mid-frame
        send_bits(frame(8'h29, 1'b0, 1'b0), 4, 0, 8'h00, 8'h00);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("midreset_keycode", keycode, 8'h00);
        chk("midreset_lost", {7'd0, key_lost}, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h29);
        chk("after_reset", keycode, 8'hA0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_keyboard_latch.md
# ps2_keyboard_latch

Keyboard front end for the Mango One: deserialises PS/2 frames from a physical keyboard, decodes scancode set 2 into 7-bit ASCII and holds the result in an Apple-I-style latch with a "key available" flag in bit 7. Its `keycode` output drives the top level's keyboard input, which is returned to the CPU at $D010. Its `keystrobe` input comes from the top level's acknowledge strobe.

## Interface
- `FILTER_LEN`, 4: consecutive identical samples required before a filtered PS/2 line changes state.
- `TIMEOUT`, 50000: clk cycles with no falling PS/2 clock edge before a partial frame is aborted.
- `clk` in 1: system clock. One clock domain; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `keystrobe` in 1: acknowledge from the top level. A rising edge clears the available flag.
- `keycode` out 8: bit 7 is key available; bits [6:0] are ASCII.
- `key_lost` out 1: one-cycle pulse when a decoded key is dropped because the latch is full.

## Operation
- **Input conditioning:** each pin passes through a 2-FF synchroniser, then a filter. The filtered value flips only after `FILTER_LEN` consecutive samples disagree with it. The frame FSM acts on a falling edge of the filtered clock (1→0) and samples the filtered data at that edge.
- **Frame FSM:**
  - IDLE: a data bit of 0 → DATA with bit count 0. A data bit of 1 stays in IDLE.
  - DATA: 8 bits, LSB first. After the 8th bit → PARITY.
  - PARITY: the stored bit is checked for odd parity over data plus parity → STOP.
  - STOP: the stop bit must be 1 and parity must be good for the byte to be emitted. In every case the FSM returns to IDLE.
  - Parity or stop error: the byte is discarded silently.
- **Watchdog:** a counter runs in any state other than IDLE and resets on each filtered falling edge. When it reaches `TIMEOUT`, the FSM returns to IDLE and the partial byte is discarded.
- **Prefix bytes:**
  - 0xF0 sets `brk`. 0xE0 sets `ext`.
  - Any other byte consumes both flags and then clears them.
  - Any byte with `ext` set is ignored, apart from clearing the flags.
- **Modifiers:**
  - 0x12 and 0x59 set or clear `shift_l` and `shift_r`. Make sets; a byte with `brk` set clears.
  - 0x14 sets or clears `ctrl` in the same way.
  - Modifiers never produce a key.
- **Breaks of non-modifiers** are ignored.
- **Make-code mapping** (US layout):
  - Letters: lowercase unless shifted. Ctrl+letter gives 0x01–0x1A; ctrl takes priority over shift.
  - Digits and punctuation: US unshifted and shifted glyphs.
  - 0x29 → 0x20, 0x5A → 0x0D, 0x66 (backspace) → 0x5F, 0x76 → 0x1B.
  - Unmapped codes produce nothing.
- **Latch:**
  - A decoded key with `keycode[7]=0` loads `{1'b1, ascii}`.
  - A decoded key with `keycode[7]=1` is dropped, `keycode` is unchanged, and `key_lost` pulses.
  - A rising edge of `keystrobe` (registered against its previous value) clears `keycode[7]`. Bits [6:0] are retained.
  - Key and ack edge in the same cycle: the new key loads with bit 7 = 1. The old key counts as consumed, and `key_lost` is not pulsed.
  - A held `keystrobe` level has no further effect.
- **Width rules:** the bit counter is 3 bits. The watchdog is sized from `TIMEOUT` (clog2). The filter counter is sized from `FILTER_LEN`.

## Timing
- **Reset (async, `reset=0`):**
  - `keycode=8'h00`, `key_lost=0`.
  - FSM in IDLE; `brk`, `ext`, `shift_l`, `shift_r` and `ctrl` cleared; watchdog, filter and bit counters at 0.
  - Filtered lines and synchroniser flops at 1 (bus idle).
  - Reset during a frame discards it. Decoding restarts with the next start bit after release.
- **Pin to filtered edge:** 2 + `FILTER_LEN` cycles from the pin change.
- **Stop-bit edge at cycle N:** byte-valid is registered at N+1. `keycode` (and any `key_lost` pulse) updates at the N+2 clock edge.
- **Acknowledge:** a `keystrobe` 0→1 sampled at edge M clears bit 7 at edge M+1.
- **Throughput:** one byte per frame, at roughly 11 PS/2 clocks per frame. There is no backpressure toward the keyboard.

## Test plan
- **Plain key:** after reset, send frame 0x1C with good parity → `keycode`=0xE1 at N+2, `key_lost`=0.
- **Shift:** send 0x12, 0x1C, F0 1C, F0 12 → exactly one key, `keycode`=0xC1. Then send 0x1C again → no load (latch full), `key_lost` pulses once.
- **Acknowledge:** with `keycode`=0xE1, raise `keystrobe` and hold it for 10 cycles → `keycode`=0x61 one cycle after the edge, unchanged thereafter. Then send 0x5A → `keycode`=0x8D.
- **Frame errors:** send 0x1C with bad parity; separately send 0x1C with stop=0 → `keycode` stays 0x00, FSM back in IDLE. A following good 0x29 → 0xA0.
- **Watchdog:** send the start bit plus 4 data bits, then stall `TIMEOUT`+5 cycles, then send a full 0x1C → `keycode`=0xE1. The partial frame must not corrupt the result.
- **Simultaneous and reset cases:**
  - With `keycode`=0xE1, make the `keystrobe` edge coincide with the N+2 load of 0x1B (Esc) → `keycode`=0x9B, no `key_lost`.
  - Assert `reset` mid-frame → outputs 0x00 and 0, and the next frame decodes normally.
